// File: rtl/inert_spi_resp.sv
// -----------------------------------------------------------------------------
// inert_spi_resp
//
// SPI responder that models the 6-axis inertial sensor on the far end of the
// gyro/accel SPI link. The sensor-side master issues 16-bit mode-0 frames:
//   bit15     : 1 = read, 0 = write
//   bits14:8  : register address
//   bits7:0   : write data (don't-care on reads)
// Reads return the addressed byte on MISO in the second half of the same
// frame. Writes and read side effects take effect only when SS_n rises after
// a complete 16-bit frame. A frame that ends early is dropped.
//
// While sampling is enabled (bit1 of register 0x0D), pitch-rate and Z-accel
// samples are latched into a shadow copy every SMPL_PERIOD clocks and INT is
// raised. A completed read of 0x22 clears INT.
//
// Register map (unlisted addresses read 0x00, writes to them are ignored):
//   0x0D, 0x10, 0x11, 0x14 : read/write configuration
//   0x22 / 0x23            : shadow pitch rate, low / high byte
//   0x2C / 0x2D            : shadow Z accel, low / high byte
//   0x1E                   : status {6'b0, overrun, data_avail}; only when
//                            INERT_STATUS_REG_EN is defined, else reads 0x00
//
// Handshake: there is no valid/ready pair here; the SPI timing is owned by the
// master. SS_n low frames a transfer, MOSI is taken on the synchronized SCLK
// rise and MISO changes on the synchronized SCLK fall. SCLK high and low
// phases must each last at least 4 clk so the synchronized edges never overlap.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   SS_n         active-low slave select
//   SCLK         SPI clock, mode 0, idle low
//   MOSI         serial data from the master, MSB first
//   MISO         serial data to the master, MSB first
//   INT          data ready, active high
//   ptch_rt_in   signed pitch-rate sample source
//   AZ_in        signed Z-accel sample source
//   int_en       bit1 of register 0x0D; sampling enabled
//
// Parameters:
//   SMPL_PERIOD     clk cycles between sample ticks while sampling is enabled
//   SS_SYNC_STAGES  synchronizer depth for SS_n, SCLK, MOSI (minimum 3)
//
// Build option:
//   INERT_STATUS_REG_EN  adds the status register at 0x1E with overrun flag
// -----------------------------------------------------------------------------
module inert_spi_resp #(
  parameter logic [15:0] SMPL_PERIOD    = 16'd4096,
  parameter int          SS_SYNC_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] ptch_rt_in,
  input  logic [15:0] AZ_in,
  output logic        int_en
);

  localparam int NS = SS_SYNC_STAGES;

  localparam logic [6:0] A_CFG = 7'h0D;
  localparam logic [6:0] A_R10 = 7'h10;
  localparam logic [6:0] A_R11 = 7'h11;
  localparam logic [6:0] A_R14 = 7'h14;
  localparam logic [6:0] A_PLO = 7'h22;
  localparam logic [6:0] A_PHI = 7'h23;
  localparam logic [6:0] A_ZLO = 7'h2C;
  localparam logic [6:0] A_ZHI = 7'h2D;
`ifdef INERT_STATUS_REG_EN
  localparam logic [6:0] A_STAT = 7'h1E;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_END  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [NS-1:0] ss_sync;
  logic [NS-1:0] sclk_sync;
  logic [NS-1:0] mosi_sync;

  logic          sclk_rise;
  logic          sclk_fall;
  logic          ss_rise;
  logic          ss_fall;
  logic          ss_active;
  logic          mosi_s;

  state_t        state;
  state_t        state_nxt;
  logic          frame_start;
  logic          cmd_done;
  logic          data_done;
  logic          commit;

  logic [3:0]    bit_cnt;
  logic [6:0]    rx_sr;
  logic [7:0]    cmd_byte;
  logic [7:0]    tx_sr;
  logic          miso_q;
  logic          cmd_rd;
  logic [6:0]    cmd_addr;
  logic [7:0]    wdata;
  logic [7:0]    rd_data;

  logic [7:0]    reg_0d;
  logic [7:0]    reg_10;
  logic [7:0]    reg_11;
  logic [7:0]    reg_14;
  logic [15:0]   ptch_sh;
  logic [15:0]   az_sh;

  logic          wr_commit;
  logic          wr_0d_now;
  logic          int_clr;
  logic          samp_en;
  logic [15:0]   smpl_cnt;
  logic          tick;
  logic          pend_q;
  logic          latch;
  logic          int_q;
`ifdef INERT_STATUS_REG_EN
  logic          ovr_q;
  logic          ovr_clr;
`endif

  // ---------------------------------------------------------------------------
  // Input synchronizers. Index 0 is the newest stage, NS-1 the oldest; an
  // edge is seen when the two oldest stages differ.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[NS-2:0], SS_n};
      sclk_sync <= {sclk_sync[NS-2:0], SCLK};
      mosi_sync <= {mosi_sync[NS-2:0], MOSI};
    end
  end

  assign sclk_rise = sclk_sync[NS-2] & ~sclk_sync[NS-1];
  assign sclk_fall = ~sclk_sync[NS-2] & sclk_sync[NS-1];
  assign ss_rise   = ss_sync[NS-2] & ~ss_sync[NS-1];
  assign ss_fall   = ~ss_sync[NS-2] & ss_sync[NS-1];
  // MOSI is taken from the same stage as the SCLK edge decision.
  assign mosi_s    = mosi_sync[NS-2];
  // Uses the oldest stage, so it stays high through the cycle that sees the
  // SS_n rise; a deferred sample therefore lands one cycle after the commit.
  assign ss_active = ~ss_sync[NS-1];

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    cmd_done    = 1'b0;
    data_done   = 1'b0;
    commit      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_nxt   = ST_CMD;
          frame_start = 1'b1;
        end
      end
      ST_CMD: begin
        if (ss_rise) begin
          state_nxt = ST_IDLE;            // short frame: dropped
        end else if (sclk_rise && (bit_cnt == 4'd7)) begin
          state_nxt = ST_DATA;
          cmd_done  = 1'b1;
        end
      end
      ST_DATA: begin
        if (ss_rise) begin
          state_nxt = ST_IDLE;            // short frame: dropped
        end else if (sclk_rise && (bit_cnt == 4'd15)) begin
          state_nxt = ST_END;
          data_done = 1'b1;
        end
      end
      ST_END: begin
        if (ss_rise) begin
          state_nxt = ST_IDLE;
          commit    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte formed by the seven bits already shifted in plus the current MOSI.
  assign cmd_byte = {rx_sr, mosi_s};

  // ---------------------------------------------------------------------------
  // Read mux, addressed by the command byte as it completes.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = 8'h00;
    case (cmd_byte[6:0])
      A_CFG:   rd_data = reg_0d;
      A_R10:   rd_data = reg_10;
      A_R11:   rd_data = reg_11;
      A_R14:   rd_data = reg_14;
      A_PLO:   rd_data = ptch_sh[7:0];
      A_PHI:   rd_data = ptch_sh[15:8];
      A_ZLO:   rd_data = az_sh[7:0];
      A_ZHI:   rd_data = az_sh[15:8];
`ifdef INERT_STATUS_REG_EN
      A_STAT:  rd_data = {6'd0, ovr_q, int_q};
`endif
      default: rd_data = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift datapath. MISO is registered and only moves on SCLK falls, so the
  // read byte loaded at the 8th rise first appears at the 8th fall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 4'd0;
      rx_sr    <= 7'd0;
      tx_sr    <= 8'h00;
      miso_q   <= 1'b0;
      cmd_rd   <= 1'b0;
      cmd_addr <= 7'd0;
      wdata    <= 8'h00;
    end else begin
      if (frame_start) begin
        bit_cnt <= 4'd0;
        tx_sr   <= 8'h00;
      end
      if (((state == ST_CMD) || (state == ST_DATA)) && sclk_rise) begin
        bit_cnt <= bit_cnt + 4'd1;
        rx_sr   <= cmd_byte[6:0];
      end
      if (state == ST_IDLE) begin
        miso_q <= 1'b0;
      end else if (sclk_fall) begin
        miso_q <= tx_sr[7];
        tx_sr  <= {tx_sr[6:0], 1'b0};
      end
      // Falls never coincide with the 8th rise, so this load is not lost.
      if (cmd_done) begin
        cmd_rd   <= cmd_byte[7];
        cmd_addr <= cmd_byte[6:0];
        tx_sr    <= cmd_byte[7] ? rd_data : 8'h00;
      end
      if (data_done) begin
        wdata <= cmd_byte;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers, written only on commit.
  // ---------------------------------------------------------------------------
  assign wr_commit = commit && !cmd_rd;
  assign int_clr   = commit && cmd_rd && (cmd_addr == A_PLO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_0d <= 8'h00;
      reg_10 <= 8'h00;
      reg_11 <= 8'h00;
      reg_14 <= 8'h00;
    end else if (wr_commit) begin
      case (cmd_addr)
        A_CFG:   reg_0d <= wdata;
        A_R10:   reg_10 <= wdata;
        A_R11:   reg_11 <= wdata;
        A_R14:   reg_14 <= wdata;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sampling. A commit to 0x0D takes effect in its own cycle, so a disable
  // stops the counter immediately and an enable starts it immediately.
  // A tick inside a frame is parked in pend_q and applied once SS_n is high,
  // so one frame never returns bytes from two different samples.
  // ---------------------------------------------------------------------------
  assign wr_0d_now = wr_commit && (cmd_addr == A_CFG);
  assign samp_en   = wr_0d_now ? wdata[1] : reg_0d[1];
  assign tick      = samp_en && (smpl_cnt == (SMPL_PERIOD - 16'd1));
  assign latch     = samp_en && (tick || pend_q) && !ss_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smpl_cnt <= 16'd0;
      pend_q   <= 1'b0;
      int_q    <= 1'b0;
      ptch_sh  <= 16'd0;
      az_sh    <= 16'd0;
    end else begin
      if (!samp_en || tick) begin
        smpl_cnt <= 16'd0;
      end else begin
        smpl_cnt <= smpl_cnt + 16'd1;
      end

      if (!samp_en || latch) begin
        pend_q <= 1'b0;
      end else if (tick) begin
        pend_q <= 1'b1;
      end

      if (latch) begin
        ptch_sh <= ptch_rt_in;
        az_sh   <= AZ_in;
      end

      // Set has priority over the read-clear.
      if (!samp_en) begin
        int_q <= 1'b0;
      end else if (latch) begin
        int_q <= 1'b1;
      end else if (int_clr) begin
        int_q <= 1'b0;
      end
    end
  end

`ifdef INERT_STATUS_REG_EN
  // Overrun: a new sample arrived while the previous one was still unread.
  assign ovr_clr = commit && cmd_rd && (cmd_addr == A_STAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (latch && int_q) begin
      ovr_q <= 1'b1;
    end else if (ovr_clr) begin
      ovr_q <= 1'b0;
    end
  end
`endif

  assign MISO   = miso_q;
  assign INT    = int_q;
  assign int_en = reg_0d[1];

endmodule

// File: tb/tb_inert_spi_resp.sv
// -----------------------------------------------------------------------------
// tb_inert_spi_resp
//
// Bench for inert_spi_resp. Drives SPI mode-0 frames with a slow SCLK
// (6 clk per phase) and checks read data, register side effects, sample
// timing, deferred sampling inside a frame, short-frame abort, the optional
// status register and a randomized register-access phase against a simple
// register-map model.
// -----------------------------------------------------------------------------
module tb_inert_spi_resp;

  localparam logic [15:0] P    = 16'd1024;
  localparam int          PI   = 1024;
  localparam int          HALF = 6;

  logic        clk;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        INT;
  logic [15:0] ptch_rt_in;
  logic [15:0] AZ_in;
  logic        int_en;

  inert_spi_resp #(
    .SMPL_PERIOD    (P),
    .SS_SYNC_STAGES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SS_n       (SS_n),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .INT        (INT),
    .ptch_rt_in (ptch_rt_in),
    .AZ_in      (AZ_in),
    .int_en     (int_en)
  );

  // ---------------------------------------------------------------------------
  // Clock, cycle counter, edge monitor
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   int_rise_cyc = -1;
  int   en_rise_cyc  = -1;
  logic int_d = 1'b0;
  logic en_d  = 1'b0;
  always @(negedge clk) begin
    if (INT && !int_d)     int_rise_cyc = cyc;
    if (int_en && !en_d)   en_rise_cyc  = cyc;
    int_d = INT;
    en_d  = int_en;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helpers
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Register-map reference model
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [128];
  logic [15:0] sh_p;
  logic [15:0] sh_a;

  function automatic logic [7:0] model_read(input logic [6:0] a);
    case (a)
      7'h22:   return sh_p[7:0];
      7'h23:   return sh_p[15:8];
      7'h2C:   return sh_a[7:0];
      7'h2D:   return sh_a[15:8];
      default: return mem[a];
    endcase
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    if (a inside {7'h0D, 7'h10, 7'h11, 7'h14}) mem[a] = d;
  endtask

  // ---------------------------------------------------------------------------
  // SPI master driver. nbits < 16 produces a short (aborted) frame.
  // rx holds the MISO bit sampled just before each rise, MSB first.
  // ---------------------------------------------------------------------------
  task automatic spi_frame(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
    rx = 16'h0000;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[15-i];
      repeat (HALF) @(negedge clk);
      rx[15-i] = MISO;
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] frame;
    logic [7:0]  exp_rd;
    logic        exp_en;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  logic [15:0] rx;
  int          bad_miso, bad_int, bad_en;
  int          budget;
  int          t1, k, tv;
  logic [7:0]  st_exp1, st_exp2;
  logic [6:0]  addr_list [10];

  initial begin
    tbl[0]  = '{16'h1053, 8'h00, 1'b0};
    tbl[1]  = '{16'h1150, 8'h00, 1'b0};
    tbl[2]  = '{16'h1460, 8'h00, 1'b0};
    tbl[3]  = '{16'h9000, 8'h53, 1'b0};
    tbl[4]  = '{16'h9100, 8'h50, 1'b0};
    tbl[5]  = '{16'h9400, 8'h60, 1'b0};
    tbl[6]  = '{16'h1F77, 8'h00, 1'b0};  // unmapped write, ignored
    tbl[7]  = '{16'h9F00, 8'h00, 1'b0};
    tbl[8]  = '{16'hA200, 8'h00, 1'b0};  // shadow still empty
    tbl[9]  = '{16'h8D00, 8'h00, 1'b0};
    tbl[10] = '{16'h0DFD, 8'h00, 1'b0};  // bit1 clear: sampling stays off
    tbl[11] = '{16'h8D00, 8'hFD, 1'b0};
    tbl[12] = '{16'h0D02, 8'h00, 1'b1};

    addr_list = '{7'h0D, 7'h10, 7'h11, 7'h14, 7'h22, 7'h23, 7'h2C, 7'h2D, 7'h1E, 7'h00};

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    sh_p = 16'h0000;
    sh_a = 16'h0000;

    // ---- reset -------------------------------------------------------------
    rst        = 1'b1;
    SS_n       = 1'b1;
    SCLK       = 1'b0;
    MOSI       = 1'b0;
    ptch_rt_in = 16'h8123;
    AZ_in      = 16'h3FC0;
    repeat (4) @(negedge clk);
    chk1("reset_miso", MISO, 1'b0);
    chk1("reset_int", INT, 1'b0);
    chk1("reset_int_en", int_en, 1'b0);
    rst = 1'b0;

    bad_miso = 0; bad_int = 0; bad_en = 0;
    for (int i = 0; i < 2 * PI; i++) begin
      @(negedge clk);
      if (MISO !== 1'b0)   bad_miso++;
      if (INT !== 1'b0)    bad_int++;
      if (int_en !== 1'b0) bad_en++;
    end
    chkn("idle_miso_nonzero_cycles", bad_miso, 0);
    chkn("idle_int_nonzero_cycles", bad_int, 0);
    chkn("idle_int_en_nonzero_cycles", bad_en, 0);

    // ---- table: init writes and read-back ----------------------------------
    for (int i = 0; i < NV; i++) begin
      spi_frame(tbl[i].frame, 16, rx);
      if (tbl[i].frame[15]) begin
        chk8($sformatf("tbl%0d_cmd_phase_miso", i), rx[15:8], 8'h00);
        chk8($sformatf("tbl%0d_read_%04h", i, tbl[i].frame), rx[7:0], tbl[i].exp_rd);
      end else begin
        chk16($sformatf("tbl%0d_write_miso", i), rx, 16'h0000);
        model_write(tbl[i].frame[14:8], tbl[i].frame[7:0]);
      end
      chk1($sformatf("tbl%0d_int_en", i), int_en, tbl[i].exp_en);
    end

    // ---- first sample: int_en shows the cycle after commit, INT SMPL_PERIOD
    //      cycles after commit, hence SMPL_PERIOD-1 cycles apart ------------
    budget = 2 * PI;
    while (!INT && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk1("first_int_seen", INT, 1'b1);
    @(negedge clk);
    chkn("first_int_latency", int_rise_cyc - en_rise_cyc, PI - 1);
    t1   = int_rise_cyc;
    sh_p = 16'h8123;
    sh_a = 16'h3FC0;

    // ---- sample read-back; INT clears after the 0x22 read -----------------
    chk1("int_before_a200", INT, 1'b1);
    spi_frame(16'hA200, 16, rx);
    chk8("read_ptch_lo", rx[7:0], 8'h23);
    chk1("int_after_a200", INT, 1'b0);
    spi_frame(16'hA300, 16, rx);
    chk8("read_ptch_hi", rx[7:0], 8'h81);
    spi_frame(16'hAC00, 16, rx);
    chk8("read_az_lo", rx[7:0], 8'hC0);
    spi_frame(16'hAD00, 16, rx);
    chk8("read_az_hi", rx[7:0], 8'h3F);

    // ---- tick inside a frame: old sample returned, latch after SS_n rise --
    k = 1;
    while (t1 + k * PI < cyc + 100) k++;
    tv = t1 + k * PI;
    wait_until(tv - 80);
    fork
      begin
        spi_frame(16'hA300, 16, rx);
      end
      begin
        wait_until(tv - 30);
        ptch_rt_in = 16'h0001;
        wait_until(tv + 20);
        chk1("int_held_during_frame", INT, 1'b0);
      end
    join
    chk8("deferred_frame_old_hi", rx[7:0], 8'h81);
    chk1("int_after_deferred", INT, 1'b1);
    sh_p = 16'h0001;
    spi_frame(16'hA300, 16, rx);
    chk8("new_ptch_hi", rx[7:0], 8'h00);
    spi_frame(16'hA200, 16, rx);
    chk8("new_ptch_lo", rx[7:0], 8'h01);
    chk1("int_cleared_again", INT, 1'b0);

    // ---- short frame: 0x0D00 write cut after 10 rises is dropped ----------
    spi_frame(16'h0D00, 10, rx);
    chk1("abort_int_en_kept", int_en, 1'b1);
    spi_frame(16'h8D00, 16, rx);
    chk8("after_abort_read_0d", rx[7:0], 8'h02);
    chk1("after_abort_int_en", int_en, 1'b1);

    // ---- two ticks without reading 0x22, then status reads ----------------
`ifdef INERT_STATUS_REG_EN
    st_exp1 = 8'h03;
    st_exp2 = 8'h01;
`else
    st_exp1 = 8'h00;
    st_exp2 = 8'h00;
`endif
    k = 1;
    while (t1 + k * PI < cyc + 5) k++;
    wait_until(t1 + k * PI + 3);
    chk1("tick_a_int", INT, 1'b1);
    wait_until(t1 + (k + 1) * PI + 3);
    chk1("tick_b_int", INT, 1'b1);
    spi_frame(16'h9E00, 16, rx);
    chk8("status_read_1", rx[7:0], st_exp1);
    spi_frame(16'h9E00, 16, rx);
    chk8("status_read_2", rx[7:0], st_exp2);
    chk1("int_kept_after_status", INT, 1'b1);

    // ---- disable sampling: INT forced low, int_en low ---------------------
    spi_frame(16'h0D00, 16, rx);
    model_write(7'h0D, 8'h00);
    chk1("disable_int_en", int_en, 1'b0);
    chk1("disable_int", INT, 1'b0);

    // ---- randomized register traffic against the model --------------------
    for (int n = 0; n < 40; n++) begin
      logic [6:0]  a;
      logic [7:0]  d;
      logic        rd;
      int          nb;
      a  = addr_list[$urandom_range(0, 9)];
      if (a == 7'h00) a = 7'($urandom_range(0, 127));
      rd = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      if (a == 7'h0D) d[1] = 1'b0;
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 16;
      spi_frame({rd, a, d}, nb, rx);
      if (nb == 16) begin
        if (rd) begin
          chk8($sformatf("rnd%0d_cmd_phase_miso", n), rx[15:8], 8'h00);
          chk8($sformatf("rnd%0d_read_%02h", n, a), rx[7:0], model_read(a));
        end else begin
          chk16($sformatf("rnd%0d_write_miso", n), rx, 16'h0000);
          model_write(a, d);
        end
      end
      chk1($sformatf("rnd%0d_int", n), INT, 1'b0);
      chk1($sformatf("rnd%0d_int_en", n), int_en, mem[7'h0D][1]);
    end

    // Final sweep of the whole map.
    for (int a = 0; a < 128; a += 1) begin
      if (a inside {'h0D, 'h10, 'h11, 'h14, 'h22, 'h23, 'h2C, 'h2D}) begin
        spi_frame({1'b1, 7'(a), 8'h00}, 16, rx);
        chk8($sformatf("sweep_read_%02h", a), rx[7:0], model_read(7'(a)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
